// File: rtl/rv32_run_controller_pkg.sv
`default_nettype none
// ============================================================================
// Package : rv32_run_pkg
// Brief   : Shared types and constants for the RV32I run controller.
// Revision: 1.0 - initial release
// ============================================================================
package rv32_run_pkg;

  // Controller states; the 3-bit width is fixed so the encoding stays stable.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RESET   = 3'd1,
    RUN     = 3'd2,
    HALTED  = 3'd3,
    TIMEOUT = 3'd4
  } run_state_t;

  // Performance counter slots, in the order they are instantiated.
  localparam int unsigned N_CNT     = 4;
  localparam int unsigned CNT_CYCLE = 0;
  localparam int unsigned CNT_STALL = 1;
  localparam int unsigned CNT_FLUSH = 2;
  localparam int unsigned CNT_WB    = 3;

endpackage : rv32_run_pkg
`default_nettype wire

// File: rtl/rv32_run_controller_if.sv
`default_nettype none
// ============================================================================
// Interface: rv32_run_controller_if
// Brief    : Control, core-status and counter signals of the run controller.
//            Suffixes are from the controller's point of view.
// Revision : 1.0 - initial release
// ============================================================================
interface rv32_run_controller_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             start_i;
  logic             abort_i;
  logic             halt_i;
  logic             stall_i;
  logic             flush_i;
  logic             wb_valid_i;
  logic [XLEN-1:0]  wb_result_i;
  logic             core_rst_n_o;
  logic             busy_o;
  logic             done_o;
  logic             timed_out_o;
  logic [CNT_W-1:0] cycle_cnt_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  logic [CNT_W-1:0] wb_cnt_o;
  logic [XLEN-1:0]  last_wb_o;

  // Controller side.
  modport slave (
    input  start_i, abort_i, halt_i, stall_i, flush_i, wb_valid_i, wb_result_i,
    output core_rst_n_o, busy_o, done_o, timed_out_o,
    output cycle_cnt_o, stall_cnt_o, flush_cnt_o, wb_cnt_o, last_wb_o
  );

  // Board / bench / SoC side.
  modport master (
    output start_i, abort_i, halt_i, stall_i, flush_i, wb_valid_i, wb_result_i,
    input  core_rst_n_o, busy_o, done_o, timed_out_o,
    input  cycle_cnt_o, stall_cnt_o, flush_cnt_o, wb_cnt_o, last_wb_o
  );
endinterface : rv32_run_controller_if
`default_nettype wire

// File: rtl/rv32_run_controller_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : rv32_sat_counter
// Brief   : W-bit counter with synchronous clear that sticks at all-ones.
// Revision: 1.0 - initial release
// ============================================================================
module rv32_sat_counter #(
  parameter int W = 32
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         clr_i,
  input  wire logic         inc_i,
  output logic [W-1:0]      q_o
);
  logic [W-1:0] q_q, q_d;

  // Clear wins over increment; increment is suppressed once all-ones.
  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (inc_i && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule : rv32_sat_counter
`default_nettype wire

// File: rtl/rv32_run_controller.sv
`default_nettype none
// ============================================================================
// Module  : rv32_run_controller
// Brief   : Sequences the core reset, runs the core under a cycle-limit
//           watchdog, detects halt and gathers run statistics.
// Revision: 1.0 - initial release
// ============================================================================
module rv32_run_controller
  import rv32_run_pkg::*;
#(
  parameter int RST_CYCLES  = 5,
  parameter int TIMEOUT_MAX = 100,
  parameter int CNT_W       = 32,
  parameter int XLEN        = 32
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  rv32_run_controller_if.slave    bus
);
  localparam int RC_W = $clog2(RST_CYCLES + 1);
  // The watchdog has its own counter so it still fires when CNT_W is too
  // narrow to reach TIMEOUT_MAX (the visible cycle counter saturates).
  localparam int TO_W = $clog2(TIMEOUT_MAX + 1);
  localparam logic [RC_W-1:0] RST_LOAD = RC_W'(RST_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_MAX - 1);

  run_state_t       state_q, state_d;
  logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [TO_W-1:0]  run_cnt_q, run_cnt_d;
  logic             core_rst_n_q, core_rst_n_d;
  logic             busy_q, done_q, timed_out_q;
  logic [XLEN-1:0]  last_wb_q, last_wb_d;
  logic             cnt_clr;
  logic             in_run;
  logic [N_CNT-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_val [N_CNT];

  assign in_run = (state_q == RUN);

  assign cnt_inc[CNT_CYCLE] = in_run;
  assign cnt_inc[CNT_STALL] = in_run & bus.stall_i;
  assign cnt_inc[CNT_FLUSH] = in_run & bus.flush_i;
  assign cnt_inc[CNT_WB]    = in_run & bus.wb_valid_i;

  // Next-state logic: abort beats halt beats watchdog; start only from rest states.
  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    run_cnt_d    = run_cnt_q;
    core_rst_n_d = core_rst_n_q;
    last_wb_d    = last_wb_q;
    cnt_clr      = 1'b0;
    unique case (state_q)
      IDLE, HALTED, TIMEOUT: begin
        if (bus.abort_i) begin
          state_d      = IDLE;
          core_rst_n_d = 1'b0;
        end else if (bus.start_i) begin
          state_d      = RESET;
          core_rst_n_d = 1'b0;
          rst_cnt_d    = RST_LOAD;
          run_cnt_d    = '0;
          last_wb_d    = '0;
          cnt_clr      = 1'b1;
        end
      end
      RESET: begin
        if (bus.abort_i) begin
          state_d      = IDLE;
          core_rst_n_d = 1'b0;
        end else if (rst_cnt_q == '0) begin
          state_d      = RUN;
          core_rst_n_d = 1'b1;
        end else begin
          rst_cnt_d = rst_cnt_q - RC_W'(1);
        end
      end
      RUN: begin
        run_cnt_d = run_cnt_q + TO_W'(1);
        if (bus.wb_valid_i) begin
          last_wb_d = bus.wb_result_i;
        end
        if (bus.abort_i) begin
          state_d      = IDLE;
          core_rst_n_d = 1'b0;
        end else if (bus.halt_i) begin
          state_d = HALTED;
        end else if (run_cnt_q == TO_LAST) begin
          state_d      = TIMEOUT;
          core_rst_n_d = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        core_rst_n_d = 1'b0;
      end
    endcase
  end

  // State, sequencing counters and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rst_cnt_q    <= '0;
      run_cnt_q    <= '0;
      core_rst_n_q <= 1'b0;
      last_wb_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timed_out_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      run_cnt_q    <= run_cnt_d;
      core_rst_n_q <= core_rst_n_d;
      last_wb_q    <= last_wb_d;
      busy_q       <= (state_d == RESET) || (state_d == RUN);
      done_q       <= (state_d == HALTED);
      timed_out_q  <= (state_d == TIMEOUT);
    end
  end

  for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
    rv32_sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (cnt_clr),
      .inc_i (cnt_inc[gi]),
      .q_o   (cnt_val[gi])
    );
  end

  assign bus.core_rst_n_o = core_rst_n_q;
  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
  assign bus.timed_out_o  = timed_out_q;
  assign bus.cycle_cnt_o  = cnt_val[CNT_CYCLE];
  assign bus.stall_cnt_o  = cnt_val[CNT_STALL];
  assign bus.flush_cnt_o  = cnt_val[CNT_FLUSH];
  assign bus.wb_cnt_o     = cnt_val[CNT_WB];
  assign bus.last_wb_o    = last_wb_q;

endmodule : rv32_run_controller
`default_nettype wire

// File: tb/tb_rv32_run_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_rv32_run_controller
// Brief   : Self-checking bench; two controllers (default and a narrow
//           CNT_W=4 / TIMEOUT_MAX=30 build) share one stimulus stream and
//           are compared every cycle against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rv32_run_controller;

  localparam int RSTC = 5;

  // Model modes (bench-local names, independent of the RTL encoding).
  localparam int M_IDLE = 0, M_RESET = 1, M_RUN = 2, M_HALT = 3, M_TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort = 1'b0, halt = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, wbv = 1'b0;
  logic [31:0] wbr = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rv32_run_controller_if #(.XLEN(32), .CNT_W(32)) bus0 ();
  rv32_run_controller_if #(.XLEN(32), .CNT_W(4))  bus1 ();

  rv32_run_controller #(.RST_CYCLES(RSTC), .TIMEOUT_MAX(100), .CNT_W(32), .XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  rv32_run_controller #(.RST_CYCLES(RSTC), .TIMEOUT_MAX(30), .CNT_W(4), .XLEN(32)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  assign bus0.start_i = start;  assign bus1.start_i = start;
  assign bus0.abort_i = abort;  assign bus1.abort_i = abort;
  assign bus0.halt_i  = halt;   assign bus1.halt_i  = halt;
  assign bus0.stall_i = stall;  assign bus1.stall_i = stall;
  assign bus0.flush_i = flush;  assign bus1.flush_i = flush;
  assign bus0.wb_valid_i  = wbv; assign bus1.wb_valid_i  = wbv;
  assign bus0.wb_result_i = wbr; assign bus1.wb_result_i = wbr;

  // ---------------- behavioural reference model ----------------
  int          p_to  [2] = '{100, 30};
  longint      p_max [2] = '{64'h0000_0000_FFFF_FFFF, 64'd15};
  int          m_mode  [2];
  int          m_rleft [2];
  int          m_runs  [2];
  bit          m_crn   [2];
  longint      m_cyc [2], m_stl [2], m_fl [2], m_wb [2];
  logic [31:0] m_last [2];

  function automatic longint sat(longint v, longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_IDLE; m_rleft[k] = 0; m_runs[k] = 0; m_crn[k] = 1'b0;
      m_cyc[k] = 0; m_stl[k] = 0; m_fl[k] = 0; m_wb[k] = 0; m_last[k] = '0;
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_mode[k] == M_RESET) begin
          if (abort) begin
            m_mode[k] = M_IDLE; m_crn[k] = 1'b0;
          end else begin
            m_rleft[k]--;
            if (m_rleft[k] == 0) begin
              m_mode[k] = M_RUN; m_crn[k] = 1'b1;
            end
          end
        end else if (m_mode[k] == M_RUN) begin
          m_runs[k]++;
          m_cyc[k] = sat(m_cyc[k] + 1, p_max[k]);
          if (stall) m_stl[k] = sat(m_stl[k] + 1, p_max[k]);
          if (flush) m_fl[k]  = sat(m_fl[k] + 1, p_max[k]);
          if (wbv) begin
            m_wb[k] = sat(m_wb[k] + 1, p_max[k]);
            m_last[k] = wbr;
          end
          if (abort) begin
            m_mode[k] = M_IDLE; m_crn[k] = 1'b0;
          end else if (halt) begin
            m_mode[k] = M_HALT;
          end else if (m_runs[k] == p_to[k]) begin
            m_mode[k] = M_TMO; m_crn[k] = 1'b0;
          end
        end else begin
          if (abort) begin
            m_mode[k] = M_IDLE; m_crn[k] = 1'b0;
          end else if (start) begin
            m_mode[k] = M_RESET; m_rleft[k] = RSTC; m_crn[k] = 1'b0; m_runs[k] = 0;
            m_cyc[k] = 0; m_stl[k] = 0; m_fl[k] = 0; m_wb[k] = 0; m_last[k] = '0;
          end
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_inst(input int k, input logic crn, input logic bsy, input logic dn,
                            input logic tmo, input logic [63:0] cyc, input logic [63:0] stl,
                            input logic [63:0] fl, input logic [63:0] wb, input logic [31:0] last);
    check_val($sformatf("d%0d.core_rst_n", k), 64'(crn), 64'(m_crn[k]));
    check_val($sformatf("d%0d.busy", k), 64'(bsy), 64'((m_mode[k] == M_RESET) || (m_mode[k] == M_RUN)));
    check_val($sformatf("d%0d.done", k), 64'(dn), 64'(m_mode[k] == M_HALT));
    check_val($sformatf("d%0d.timed_out", k), 64'(tmo), 64'(m_mode[k] == M_TMO));
    check_val($sformatf("d%0d.cycle_cnt", k), cyc, 64'(m_cyc[k]));
    check_val($sformatf("d%0d.stall_cnt", k), stl, 64'(m_stl[k]));
    check_val($sformatf("d%0d.flush_cnt", k), fl, 64'(m_fl[k]));
    check_val($sformatf("d%0d.wb_cnt", k), wb, 64'(m_wb[k]));
    check_val($sformatf("d%0d.last_wb", k), 64'(last), 64'(m_last[k]));
  endtask

  task automatic check_all();
    check_inst(0, bus0.core_rst_n_o, bus0.busy_o, bus0.done_o, bus0.timed_out_o,
               64'(bus0.cycle_cnt_o), 64'(bus0.stall_cnt_o), 64'(bus0.flush_cnt_o),
               64'(bus0.wb_cnt_o), bus0.last_wb_o);
    check_inst(1, bus1.core_rst_n_o, bus1.busy_o, bus1.done_o, bus1.timed_out_o,
               64'(bus1.cycle_cnt_o), 64'(bus1.stall_cnt_o), 64'(bus1.flush_cnt_o),
               64'(bus1.wb_cnt_o), bus1.last_wb_o);
  endtask

  // One clock: model consumes the inputs seen at the edge, outputs checked 1 unit later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic async_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check_val("async.core_rst_n", 64'(bus0.core_rst_n_o), 64'd0);
    check_val("async.cycle_cnt", 64'(bus0.cycle_cnt_o), 64'd0);
    #1;
    rst_n = 1'b1;
  endtask

  // Start pulse, then measure how many visible cycles the core is held in reset.
  task automatic run_reset(output int len);
    abort = 1'b0; halt = 1'b0; stall = 1'b0; flush = 1'b0; wbv = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("start.clr_cycle", 64'(bus0.cycle_cnt_o), 64'd0);
    check_val("start.busy", 64'(bus0.busy_o), 64'd1);
    len = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus0.busy_o && !bus0.core_rst_n_o) len++;
      if (bus0.core_rst_n_o) break;
      tick();
    end
    check_val("reset.len", 64'(len), 64'(RSTC));
    check_val("reset.released", 64'(bus0.core_rst_n_o), 64'd1);
  endtask

  initial begin
    int len;
    int n;
    model_reset();
    // Power-on reset values.
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check_val("idle.core_rst_n", 64'(bus0.core_rst_n_o), 64'd0);

    // Reset sequencing, then the halting stub program.
    run_reset(len);
    for (int i = 0; i < 200; i++) begin
      n = m_runs[0];
      halt  = (n >= 39);
      stall = (n < 10);
      flush = (n >= 10) && (n < 13);
      wbv   = (n % 2) == 1;
      wbr   = 32'(n);
      tick();
      if (bus0.done_o) break;
    end
    check_val("halt.done", 64'(bus0.done_o), 64'd1);
    check_val("halt.cycle_cnt", 64'(bus0.cycle_cnt_o), 64'd40);
    check_val("halt.stall_cnt", 64'(bus0.stall_cnt_o), 64'd10);
    check_val("halt.flush_cnt", 64'(bus0.flush_cnt_o), 64'd3);
    check_val("halt.wb_cnt", 64'(bus0.wb_cnt_o), 64'd20);
    check_val("halt.last_wb", 64'(bus0.last_wb_o), 64'd39);
    check_val("halt.core_rst_n", 64'(bus0.core_rst_n_o), 64'd1);
    repeat (3) tick();
    check_val("halt.sticky", 64'(bus0.done_o), 64'd1);

    // Watchdog: halt never comes; stall stuck high.
    run_reset(len);
    for (int i = 0; i < 300; i++) begin
      stall = 1'b1;
      flush = $urandom_range(0, 1) != 0;
      wbv   = $urandom_range(0, 1) != 0;
      wbr   = $urandom;
      tick();
      if (bus0.timed_out_o) break;
    end
    check_val("tmo.timed_out", 64'(bus0.timed_out_o), 64'd1);
    check_val("tmo.cycle_cnt", 64'(bus0.cycle_cnt_o), 64'd100);
    check_val("tmo.core_rst_n", 64'(bus0.core_rst_n_o), 64'd0);
    check_val("tmo.busy", 64'(bus0.busy_o), 64'd0);
    check_val("narrow.stall_sat", 64'(bus1.stall_cnt_o), 64'd15);
    check_val("narrow.cycle_sat", 64'(bus1.cycle_cnt_o), 64'd15);
    check_val("narrow.timed_out", 64'(bus1.timed_out_o), 64'd1);

    // Halt on the very last allowed cycle wins over the watchdog.
    run_reset(len);
    stall = 1'b0;
    for (int i = 0; i < 300; i++) begin
      halt = (m_runs[0] >= 99);
      tick();
      if (bus0.done_o || bus0.timed_out_o) break;
    end
    check_val("edge.done", 64'(bus0.done_o), 64'd1);
    check_val("edge.timed_out", 64'(bus0.timed_out_o), 64'd0);
    check_val("edge.cycle_cnt", 64'(bus0.cycle_cnt_o), 64'd100);

    // Restart from HALTED, then abort mid-run.
    run_reset(len);
    for (int i = 0; i < 19; i++) begin
      stall = $urandom_range(0, 1) != 0;
      wbv   = $urandom_range(0, 1) != 0;
      wbr   = $urandom;
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("abort.cycle_cnt", 64'(bus0.cycle_cnt_o), 64'd20);
    check_val("abort.busy", 64'(bus0.busy_o), 64'd0);
    check_val("abort.core_rst_n", 64'(bus0.core_rst_n_o), 64'd0);
    repeat (3) tick();
    check_val("abort.held", 64'(bus0.cycle_cnt_o), 64'd20);

    // Halt already high when RUN is entered.
    abort = 1'b0; stall = 1'b0; flush = 1'b0; wbv = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    halt = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus0.done_o) break;
    end
    check_val("early_halt.done", 64'(bus0.done_o), 64'd1);
    check_val("early_halt.cycle_cnt", 64'(bus0.cycle_cnt_o), 64'd1);
    halt = 1'b0;

    // Asynchronous reset in the middle of a run.
    run_reset(len);
    repeat (10) tick();
    async_pulse();
    repeat (2) tick();

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      start = (r < 3);
      abort = (r >= 3) && (r < 5);
      if ($urandom_range(0, 19) == 0) halt = ~halt;
      stall = $urandom_range(0, 1) != 0;
      flush = $urandom_range(0, 3) == 0;
      wbv   = $urandom_range(0, 1) != 0;
      wbr   = $urandom;
      if ($urandom_range(0, 699) == 0) async_pulse();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_rv32_run_controller
`default_nettype wire
